pattern_serializer: RTL and testbench

//   Upstream feeder for the serial pattern-detection path. Accepts WIDTH-bit words on a

---
 rtl/pattern_serializer.sv | 93 +++++++++
 tb/tb_pattern_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// MSB-first word serializer with a valid/ready input and zero-gap back-to-back frames.
// Optional trailing even-parity bit per frame when `PATTERN_SERIALIZER_PARITY_EN is defined.
module pattern_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             frame_done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PATTERN_SERIALIZER_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sreg;
    logic             last_bit;
    logic             xfer;

    assign last_bit = (state == S_SHIFT) && (cnt == CNT_LAST);
    assign a_valid  = (state != S_IDLE);
    assign busy     = (state != S_IDLE);
    assign xfer     = din_valid && din_ready;

`ifdef PATTERN_SERIALIZER_PARITY_EN
    // Parity of the whole word is latched at load, since sreg is consumed while shifting.
    logic par;

    assign din_ready  = !reset && ((state == S_IDLE) || (state == S_PARITY));
    assign frame_done = (state == S_PARITY);
    assign a          = (state == S_SHIFT)  ? sreg[WIDTH-1] :
                        (state == S_PARITY) ? par : IDLE_BIT;
`else
    assign din_ready  = !reset && ((state == S_IDLE) || last_bit);
    assign frame_done = last_bit;
    assign a          = (state == S_SHIFT) ? sreg[WIDTH-1] : IDLE_BIT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            sreg  <= '0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: ;
                S_SHIFT: begin
                    sreg <= sreg << 1;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef PATTERN_SERIALIZER_PARITY_EN
                S_PARITY: state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase

            // A transfer can only occur where the frame is free to restart, so it overrides
            // the end-of-frame return to IDLE and gives zero-gap streaming.
            if (xfer) begin
                state <= S_SHIFT;
                sreg  <= din;
                cnt   <= '0;
`ifdef PATTERN_SERIALIZER_PARITY_EN
                par   <= ^din;
`endif
            end
        end
    end
endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: queue-based bit-stream model checked every cycle, plus
// directed frames with literal expectations. Honours `PATTERN_SERIALIZER_PARITY_EN.
module tb_pattern_serializer;
    localparam int   WIDTH    = 8;
    localparam logic IDLE_BIT = 1'b1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready, a, a_valid, busy, frame_done;

    pattern_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .a(a), .a_valid(a_valid), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: the bits still owed on the line, front = bit on the line this cycle.
    bit q[$];
    bit m_xfer = 1'b0;
    bit started = 1'b0;

    always @(posedge clk) begin
        m_xfer = 1'b0;
        if (reset) begin
            q.delete();
            started = 1'b1;
        end else begin
            m_xfer = din_valid && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (m_xfer) begin
                for (int i = WIDTH - 1; i >= 0; i--) q.push_back(din[i]);
`ifdef PATTERN_SERIALIZER_PARITY_EN
                q.push_back(^din);
`endif
            end
        end
    end

    logic [31:0] hist = '0;
    int nvalid = 0;
    int fdcnt = 0;
    int idle_zero = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("a",          {31'd0, a},          {31'd0, (q.size() > 0) ? q[0] : IDLE_BIT});
            chk("a_valid",    {31'd0, a_valid},    {31'd0, q.size() > 0});
            chk("busy",       {31'd0, busy},       {31'd0, q.size() > 0});
            chk("frame_done", {31'd0, frame_done}, {31'd0, q.size() == 1});
            chk("din_ready",  {31'd0, din_ready},  {31'd0, !reset && (q.size() <= 1)});
            if (a_valid === 1'b1) begin
                hist = {hist[30:0], a};
                nvalid++;
            end else if (a !== IDLE_BIT) begin
                idle_zero++;
            end
            if (frame_done === 1'b1) fdcnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until the model sees it accepted; valid stays high.
    task automatic send(input logic [WIDTH-1:0] w);
        int n;
        din = w;
        din_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_xfer && n < 100);
        if (!m_xfer) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        if (q.size() > 0) chk("idle_timeout", 32'd0, 32'd1);
        tick();
    endtask

    int nv0, fd0, trans;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();

`ifndef PATTERN_SERIALIZER_PARITY_EN
        // Single A5 frame.
        nv0 = nvalid; fd0 = fdcnt;
        send(8'hA5);
        din_valid = 1'b0;
        wait_idle();
        chk("a5_bits", {24'd0, hist[7:0]}, 32'h0000_00A5);
        chk("a5_nvalid", nvalid - nv0, 8);
        chk("a5_fd", fdcnt - fd0, 1);

        // Back-to-back 0F, F0 with valid held.
        nv0 = nvalid; fd0 = fdcnt;
        send(8'h0F);
        send(8'hF0);
        din_valid = 1'b0;
        wait_idle();
        chk("stream_bits", {16'd0, hist[15:0]}, 32'h0000_0FF0);
        chk("stream_nvalid", nvalid - nv0, 16);
        chk("stream_fd", fdcnt - fd0, 2);

        // Reset aborts FF mid-frame, then 00 serialises cleanly.
        send(8'hFF);
        din_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_a", {31'd0, a}, 32'd1);
        chk("abort_valid", {31'd0, a_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_fd", {31'd0, frame_done}, 32'd0);
        tick();
        nv0 = nvalid;
        send(8'h00);
        din_valid = 1'b0;
        wait_idle();
        chk("after_abort_bits", {24'd0, hist[7:0]}, 32'd0);
        chk("after_abort_nvalid", nvalid - nv0, 8);

        // 3C presented mid-frame of C3 waits for the final bit.
        nv0 = nvalid;
        send(8'hC3);
        din_valid = 1'b0;
        tick();
        tick();
        send(8'h3C);
        din_valid = 1'b0;
        wait_idle();
        chk("held_bits", {16'd0, hist[15:0]}, 32'h0000_C33C);
        chk("held_nvalid", nvalid - nv0, 16);

        // 55 has four rising transitions; idle line never drops.
        send(8'h55);
        din_valid = 1'b0;
        wait_idle();
        trans = 0;
        for (int i = 0; i < 7; i++) if (!hist[i+1] && hist[i]) trans++;
        chk("rise_55", trans, 4);
        for (int i = 0; i < 10; i++) tick();
`else
        // 07 then 03 with trailing even parity.
        nv0 = nvalid; fd0 = fdcnt;
        send(8'h07);
        din_valid = 1'b0;
        wait_idle();
        chk("par07_bits", {23'd0, hist[8:0]}, 32'h0000_000F);
        chk("par07_nvalid", nvalid - nv0, 9);
        chk("par07_fd", fdcnt - fd0, 1);
        send(8'h03);
        din_valid = 1'b0;
        wait_idle();
        chk("par03_bits", {23'd0, hist[8:0]}, 32'h0000_0006);
`endif
        chk("idle_zero", idle_zero, 0);

        // Randomised traffic with occasional resets; din churns while not presented.
        for (int i = 0; i < 3000; i++) begin
            if (!din_valid || m_xfer) begin
                din_valid = ($urandom % 10) < 6;
                din = WIDTH'($urandom);
            end
            reset = ($urandom % 80) == 0;
            tick();
        end
        reset = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
